// File: rtl/spi_dcs_master_if.sv
// Host and SPI signal bundle for spi_dcs_master.
//   master modport : the controller's view (host request in, SPI pins out, m_miso in)
//   slave modport  : the host / SPI-slave view (drives req/wr/addr/wdata and m_miso)
// Host side : req, wr, addr[7:0], wdata[15:0] -> ready, done, rdata[15:0], err
// SPI side  : m_scl, m_mosi, m_cs_addr, m_cs_data out; m_miso in
interface spi_dcs_master_if;
    logic        req;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic        err;
    logic        m_scl;
    logic        m_mosi;
    logic        m_miso;
    logic        m_cs_addr;
    logic        m_cs_data;

    modport master (
        input  req, wr, addr, wdata, m_miso,
        output ready, done, rdata, err, m_scl, m_mosi, m_cs_addr, m_cs_data
    );

    modport slave (
        output req, wr, addr, wdata, m_miso,
        input  ready, done, rdata, err, m_scl, m_mosi, m_cs_addr, m_cs_data
    );
endinterface

// File: rtl/spi_dcs_master.sv
// SPI master with two chip selects: an 8-bit address phase under m_cs_addr, then a
// 16-bit data phase under m_cs_data. Writes send wdata; reads send zeros and capture
// m_miso into rdata. A full transaction takes 53*CLK_DIV clk cycles.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset, aborts any transaction
//   bus   : spi_dcs_master_if.master (host handshake plus SPI pins)
// Parameter CLK_DIV : SCL half-period in clk cycles (2..255).
// Optional macro SPI_DCS_M_ERR_EN : reject requests whose wr bit disagrees with the
// address window (addr[7]=1 is the read window) and pulse err instead of executing.
module spi_dcs_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_dcs_master_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle, StASetup, StAShift, StAHold, StGap, StDSetup, StDShift, StDHold
    } state_e;

    localparam logic [8:0] HalfM1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] FullM1 = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] Half   = 9'(CLK_DIV);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;     // cycle count within a state, or within one bit
    logic [3:0]  bit_q, bit_d;
    logic [15:0] sh_q, sh_d;       // outgoing bits, MSB on the wire
    logic [15:0] rx_q, rx_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        done_q, done_d;
`ifdef SPI_DCS_M_ERR_EN
    logic        err_q, err_d;
`endif

    logic shifting;
    logic half_end;
    logic bit_end;

    assign shifting = (state_q == StAShift) || (state_q == StDShift);
    assign half_end = (cnt_q == HalfM1);
    assign bit_end  = (cnt_q == FullM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef SPI_DCS_M_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
`ifdef SPI_DCS_M_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 9'd1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef SPI_DCS_M_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.req) begin
`ifdef SPI_DCS_M_ERR_EN
                    // Write into the read window or read from the write window.
                    if (bus.wr == bus.addr[7]) begin
                        err_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = StASetup;
                        wr_d    = bus.wr;
                        wdata_d = bus.wdata;
                        sh_d    = {bus.addr, 8'h00};
                    end
                end
            end
            StASetup: if (half_end) begin
                state_d = StAShift;
                cnt_d   = '0;
                bit_d   = '0;
            end
            StAShift: if (bit_end) begin
                cnt_d = '0;
                sh_d  = {sh_q[14:0], 1'b0};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd7) state_d = StAHold;
            end
            StAHold: if (half_end) begin
                state_d = StGap;
                cnt_d   = '0;
            end
            StGap: if (half_end) begin
                state_d = StDSetup;
                cnt_d   = '0;
                sh_d    = wr_q ? wdata_q : 16'h0000;
            end
            StDSetup: if (half_end) begin
                state_d = StDShift;
                cnt_d   = '0;
                bit_d   = '0;
            end
            StDShift: begin
                // This edge is the one that raises m_scl.
                if (half_end && !wr_q) rx_d = {rx_q[14:0], bus.m_miso};
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {sh_q[14:0], 1'b0};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) state_d = StDHold;
                end
            end
            StDHold: if (half_end) begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (!wr_q) rdata_d = rx_q;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.m_cs_addr = !((state_q == StASetup) || (state_q == StAShift) ||
                             (state_q == StAHold));
    assign bus.m_cs_data = !((state_q == StDSetup) || (state_q == StDShift) ||
                             (state_q == StDHold));
    assign bus.m_scl     = shifting && (cnt_q >= Half);
    assign bus.m_mosi    = shifting && sh_q[15];
`ifdef SPI_DCS_M_ERR_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dcs_master.sv
// Directed bench for spi_dcs_master: CLK_DIV=4 instance for write/read/back-to-back/
// reset/window cases, CLK_DIV=2 instance for latency and SCL phase width.
module tb_spi_dcs_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_dcs_master_if bus1 ();
    spi_dcs_master_if bus2 ();

    spi_dcs_master #(.CLK_DIV(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_dcs_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] slave_resp(input logic [7:0] a);
        case (a)
            8'h81:   return 16'h1234;
            8'h88:   return 16'hBEEF;
            default: return 16'h0000;
        endcase
    endfunction

    // Slave model / monitor for dut1, evaluated away from the active edge.
    logic [7:0]  a_bits;
    logic [15:0] d_bits, resp1;
    int a_cnt, d_cnt, overlap, idle_viol, mosi_viol, err_seen, done_seen;
    logic scl_p = 1'b0, mosi_p = 1'b0, csa_p = 1'b1, csd_p = 1'b1;

    always @(negedge clk) begin
        if (!bus1.m_cs_addr && !bus1.m_cs_data) overlap++;
        if (bus1.m_cs_addr && bus1.m_cs_data && (bus1.m_scl || bus1.m_mosi)) idle_viol++;
        if (bus1.m_scl && scl_p && (bus1.m_mosi != mosi_p)) mosi_viol++;
        if (bus1.err) err_seen++;
        if (bus1.done) done_seen++;
        if (!bus1.m_cs_addr && csa_p) begin a_bits = '0; a_cnt = 0; end
        if (!bus1.m_cs_data && csd_p) begin
            d_bits = '0;
            d_cnt = 0;
            resp1 = slave_resp(a_bits);
            bus1.m_miso = resp1[15];
        end
        if (bus1.m_scl && !scl_p) begin
            if (!bus1.m_cs_addr) begin
                a_bits = {a_bits[6:0], bus1.m_mosi};
                a_cnt++;
            end else if (!bus1.m_cs_data) begin
                d_bits = {d_bits[14:0], bus1.m_mosi};
                d_cnt++;
                bus1.m_miso = (d_cnt < 16) ? resp1[4'(15 - d_cnt)] : 1'b0;
            end
        end
        scl_p = bus1.m_scl; mosi_p = bus1.m_mosi;
        csa_p = bus1.m_cs_addr; csd_p = bus1.m_cs_data;
    end

    // Slave model / monitor for dut2 with SCL phase-width tracking.
    logic [7:0]  a_bits2;
    logic [15:0] resp2;
    int d_cnt2, run2, min_hi = 999, max_hi = 0, min_lo = 999, max_lo = 0;
    logic scl2_p = 1'b0, csa2_p = 1'b1, csd2_p = 1'b1, lo_valid = 1'b0;

    always @(negedge clk) begin
        if (!bus2.m_cs_addr && csa2_p) a_bits2 = '0;
        if (!bus2.m_cs_data && csd2_p) begin
            d_cnt2 = 0;
            resp2 = slave_resp(a_bits2);
            bus2.m_miso = resp2[15];
        end
        if (bus2.m_cs_addr && bus2.m_cs_data) lo_valid = 1'b0;
        if (bus2.m_scl != scl2_p) begin
            if (bus2.m_scl) begin
                if (lo_valid) begin
                    if (run2 < min_lo) min_lo = run2;
                    if (run2 > max_lo) max_lo = run2;
                end
                if (!bus2.m_cs_addr) a_bits2 = {a_bits2[6:0], bus2.m_mosi};
                else if (!bus2.m_cs_data) begin
                    d_cnt2++;
                    bus2.m_miso = (d_cnt2 < 16) ? resp2[4'(15 - d_cnt2)] : 1'b0;
                end
            end else begin
                if (run2 < min_hi) min_hi = run2;
                if (run2 > max_hi) max_hi = run2;
                lo_valid = 1'b1;
            end
            run2 = 1;
        end else begin
            run2++;
        end
        scl2_p = bus2.m_scl; csa2_p = bus2.m_cs_addr; csd2_p = bus2.m_cs_data;
    end

    // One transaction; lat = clk edges from acceptance to the cycle showing done.
    task automatic txn(input bit d2, input logic w, input logic [7:0] a,
                       input logic [15:0] wd, output int lat, output logic [15:0] rd);
        lat = 0;
        rd  = 'x;
        @(negedge clk);
        for (int i = 0; i < 1000 && !(d2 ? bus2.ready : bus1.ready); i++) @(negedge clk);
        if (d2) begin bus2.req = 1'b1; bus2.wr = w; bus2.addr = a; bus2.wdata = wd; end
        else    begin bus1.req = 1'b1; bus1.wr = w; bus1.addr = a; bus1.wdata = wd; end
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        bus2.req = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (d2 ? bus2.done : bus1.done) begin
                lat = k;
                rd  = d2 ? bus2.rdata : bus1.rdata;
                break;
            end
        end
    endtask

    int lat, first_done, second_done, dsn;
    logic [15:0] rd;

    initial begin
        bus1.req = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        bus2.req = 1'b0; bus2.wr = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus1.ready, 1);
        check("rst_done", bus1.done, 0);
        check("rst_err", bus1.err, 0);
        check("rst_rdata", bus1.rdata, 0);
        check("rst_pins", {bus1.m_scl, bus1.m_mosi, bus1.m_cs_addr, bus1.m_cs_data}, 4'b0011);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 0x01 <- 0xA5C3
        txn(0, 1'b1, 8'h01, 16'hA5C3, lat, rd);
        check("wr_lat", lat, 212);
        check("wr_addr_bits", a_bits, 8'h01);
        check("wr_addr_cnt", a_cnt, 8);
        check("wr_data_bits", d_bits, 16'hA5C3);
        check("wr_data_cnt", d_cnt, 16);
        check("wr_ready_at_done", bus1.ready, 1);
        check("wr_rdata_hold", bus1.rdata, 0);

        // Read 0x81, slave returns 0x1234
        txn(0, 1'b0, 8'h81, 16'hFFFF, lat, rd);
        check("rd_lat", lat, 212);
        check("rd_addr_bits", a_bits, 8'h81);
        check("rd_mosi_zero", d_bits, 16'h0000);
        check("rd_rdata_at_done", rd, 16'h1234);
        @(posedge clk);
        #1;
        check("rd_done_pulse", bus1.done, 0);

        // A following write must not disturb rdata
        txn(0, 1'b1, 8'h22, 16'h0001, lat, rd);
        check("wr2_lat", lat, 212);
        check("wr2_rdata_hold", rd, 16'h1234);

        // Back-to-back writes with req held high
        @(negedge clk);
        bus1.req = 1'b1; bus1.wr = 1'b1; bus1.addr = 8'h02; bus1.wdata = 16'h0F0F;
        @(posedge clk);
        first_done = 0;
        second_done = 0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (k == 213) begin
                check("b2b_accept_ready", bus1.ready, 0);
                check("b2b_accept_csa", bus1.m_cs_addr, 0);
            end
            if (bus1.done) begin
                if (first_done == 0) begin
                    first_done = k;
                    check("b2b_ready_on_done", bus1.ready, 1);
                    check("b2b_gap_cs", {bus1.m_cs_addr, bus1.m_cs_data}, 2'b11);
                end else begin
                    second_done = k;
                    bus1.req = 1'b0;
                    break;
                end
            end
        end
        bus1.req = 1'b0;
        check("b2b_first_done", first_done, 212);
        check("b2b_second_done", second_done, 425);
        check("b2b_data_bits", d_bits, 16'h0F0F);

        // Reset during data bit 7 (SCL high)
        @(negedge clk);
        bus1.req = 1'b1; bus1.wr = 1'b1; bus1.addr = 8'h03; bus1.wdata = 16'hFFFF;
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        repeat (141) @(posedge clk);
        #1;
        check("abort_pre_state", {bus1.m_cs_data, bus1.m_scl, bus1.m_mosi}, 3'b011);
        dsn = done_seen;
        rst_n = 1'b0;
        #1;
        check("abort_ready", bus1.ready, 1);
        check("abort_pins", {bus1.m_scl, bus1.m_mosi, bus1.m_cs_addr, bus1.m_cs_data}, 4'b0011);
        check("abort_rdata", bus1.rdata, 0);
        check("abort_done_err", {bus1.done, bus1.err}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_done", done_seen - dsn, 0);
        txn(0, 1'b0, 8'h81, 16'h0000, lat, rd);
        check("post_abort_lat", lat, 212);
        check("post_abort_rdata", rd, 16'h1234);

        // Window-mismatched request: write to 0x84
`ifdef SPI_DCS_M_ERR_EN
        dsn = err_seen;
        @(negedge clk);
        bus1.req = 1'b1; bus1.wr = 1'b1; bus1.addr = 8'h84; bus1.wdata = 16'h5555;
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        check("err_pulse", bus1.err, 1);
        check("err_ready", bus1.ready, 1);
        check("err_cs", {bus1.m_cs_addr, bus1.m_cs_data}, 2'b11);
        @(posedge clk);
        #1;
        check("err_one_cycle", bus1.err, 0);
        check("err_still_idle", bus1.ready, 1);
`else
        dsn = err_seen;
        txn(0, 1'b1, 8'h84, 16'h5555, lat, rd);
        check("win_exec_lat", lat, 212);
        check("win_exec_addr", a_bits, 8'h84);
        check("win_exec_data", d_bits, 16'h5555);
        check("win_no_err", err_seen - dsn, 0);
`endif

        // CLK_DIV=2 read of 0x88
        txn(1, 1'b0, 8'h88, 16'h0000, lat, rd);
        check("div2_lat", lat, 106);
        check("div2_rdata", rd, 16'hBEEF);
        check("div2_min_hi", min_hi, 2);
        check("div2_max_hi", max_hi, 2);
        check("div2_min_lo", min_lo, 2);
        check("div2_max_lo", max_lo, 2);

        // Whole-run protocol invariants on dut1
        check("cs_overlap", overlap, 0);
        check("idle_pins", idle_viol, 0);
        check("mosi_while_scl_high", mosi_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_dcs_master.md
SPI_DCS_MASTER -- requirements
Module: spi_dcs_master

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning SCL half-period in clk cycles (legal range 2..255).
REQ-002 clk  input  1  system clock; all logic on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  host transaction request, sampled when ready=1.
REQ-005 wr  input  1  1=write transaction, 0=read transaction.
REQ-006 addr  input  8  register address as sent on the wire (read window 0x80-0xFF, write window 0x00-0x7F).
REQ-007 wdata  input  16  write data.
REQ-008 ready  output  1  1 = idle, request will be accepted.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rdata  output  16  data captured by the last completed read.
REQ-011 err  output  1  one-cycle pulse on a rejected request (only with SPI_DCS_M_ERR_EN).
REQ-012 m_scl  output  1  SPI clock to slave, idle low.
REQ-013 m_mosi  output  1  serial data to slave sdi.
REQ-014 m_miso  input  1  serial data from slave sdo.
REQ-015 m_cs_addr  output  1  address-phase chip select, active low.
REQ-016 m_cs_data  output  1  data-phase chip select, active low.

Function
REQ-017 Acceptance: at a posedge with req=1 and ready=1, the block latches wr/addr/wdata, drops ready on the next cycle, and ignores req until ready returns.
REQ-018 States: IDLE -> A_SETUP -> A_SHIFT -> A_HOLD -> GAP -> D_SETUP -> D_SHIFT -> D_HOLD -> IDLE. Every state except IDLE and the two shift states lasts CLK_DIV cycles.
REQ-019 Chip selects: m_cs_addr is low in A_SETUP, A_SHIFT and A_HOLD. m_cs_data is low in D_SETUP, D_SHIFT and D_HOLD. They are never low together, and both are high in IDLE and GAP.
REQ-020 Bit timing: each bit has m_scl low for CLK_DIV cycles, then high for CLK_DIV cycles. m_mosi changes only while m_scl is low, at the start of the bit.
REQ-021 A_SHIFT shifts out addr[7:0] MSB first (8 bits).
REQ-022 D_SHIFT lasts 16 bits, MSB first: a write sends wdata, a read sends 0.
REQ-023 MISO sampling: m_miso is sampled on the clk edge that raises m_scl; during a write it is ignored.
REQ-024 rdata updates only when a read completes, in the same cycle done pulses; otherwise it holds its value.
REQ-025 Latency: done pulses exactly 53*CLK_DIV clk cycles after the acceptance edge. ready=1 in the same cycle as done, so back-to-back requests are allowed.
REQ-026 m_mosi=0 and m_scl=0 whenever both chip selects are high.
REQ-027 The wr bit is not encoded on the wire; addr is sent unchanged, and the caller selects the window.

Reset
REQ-028 Asserting rst_n aborts any transaction immediately (asynchronous), including mid-bit.
REQ-029 Reset values: ready=1, done=0, err=0, rdata=0, m_scl=0, m_mosi=0, m_cs_addr=1, m_cs_data=1, state IDLE.
REQ-030 No done pulse is generated for an aborted transaction.

Configuration
REQ-031 Macro SPI_DCS_M_ERR_EN defined: a request with wr=1 and addr[7]=1, or wr=0 and addr[7]=0, is rejected. The block pulses err for one cycle on the cycle after the request, drives no SPI activity, and keeps ready=1.
REQ-032 Macro SPI_DCS_M_ERR_EN undefined: err is tied to 0 and every request is executed as given.

Verification
REQ-033 Write: CLK_DIV=4, write addr=0x01, wdata=0xA5C3 -> mosi bits 00000001 under cs_addr, then 1010010111000011 under cs_data; done at cycle 212 after acceptance.
REQ-034 Read: slave model returns 0x1234 for addr=0x81 -> mosi sends 0x81 then 16 zeros, rdata=0x1234 when done pulses; a following write leaves rdata=0x1234.
REQ-035 Back-to-back: req held high for two writes -> second acceptance on the done cycle; GAP/idle timing is preserved, and the chip selects never overlap.
REQ-036 Reset mid-transaction: rst_n low during D_SHIFT bit 7 -> all outputs at reset values within the same cycle, no done pulse; the next request completes normally.
REQ-037 Error (SPI_DCS_M_ERR_EN): wr=1, addr=0x84 -> err pulses for one cycle, chip selects stay high, ready stays 1. Without the macro, the same request is executed and err stays 0.
REQ-038 CLK_DIV=2: read addr=0x88 -> done at cycle 106, and each m_scl phase is 2 cycles wide.
